// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesting ports. A small
// three-state controller (IDLE -> EXEC -> DONE) picks a winner, latches that
// port's operands into the ALU operand latches, captures the ALU result one
// cycle later and pulses the winner's done. Arbitration is round-robin by
// default, or fixed priority for port 0 when FIXED_PRIO is non-zero.
//
// Ports
//   clk            in   clock, all state on the rising edge
//   reset_n        in   asynchronous active-low reset
//   req0/req1      in   per-port request, held with stable operands until done
//   a0/b0, a1/b1   in   8-bit operands per port
//   op0/op1        in   3-bit ALU operation per port (passed through untouched)
//   gnt0/gnt1      out  registered, high during the EXEC cycle of that port
//   done0/done1    out  registered one-cycle pulse, res valid for that port
//   res            out  registered ALU result of the last completed transaction
//   res_zero       out  registered ALU zero flag of the last transaction
//   busy           out  high while in EXEC or DONE
//   alu_a/alu_b    out  operands to the shared ALU (from the operand latches)
//   alu_op         out  operation to the shared ALU (from the operand latch)
//   alu_y          in   combinational ALU result
//   alu_zero       in   combinational ALU zero flag
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] a0,
   input  logic [7:0] b0,
   input  logic [7:0] a1,
   input  logic [7:0] b1,
   input  logic [2:0] op0,
   input  logic [2:0] op1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [7:0] res,
   output logic       res_zero,
   output logic       busy,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [7:0] alu_y,
   input  logic       alu_zero
);

   localparam bit FixedPrio = (FIXED_PRIO != 0);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e     state_q, state_d;

   // Operand latches feeding the shared ALU.
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [2:0] op_q, op_d;

   // sel: port currently in flight (0/1). last: port served most recently;
   // resets to 1 so port 0 wins the first simultaneous request.
   logic       sel_q, sel_d;
   logic       last_q, last_d;

   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic       done0_q, done0_d;
   logic       done1_q, done1_d;
   logic [7:0] res_q, res_d;
   logic       zero_q, zero_d;

   // Arbitration. Port 0 wins when alone, under fixed priority, or when port 1
   // was the last one served; otherwise a pending port 1 takes it.
   logic       win0, win1;

   always_comb begin
      win0 = req0 && (!req1 || FixedPrio || last_q);
      win1 = req1 && !win0;
   end

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         sel_q   <= 1'b0;
         last_q  <= 1'b1;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               state_d = StExec;
            end
         end
         StExec:  state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next values of the registered outputs and latches
   // ---------------------------------------------------------------------------
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      sel_d   = sel_q;
      last_d  = last_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      res_d   = res_q;
      zero_d  = zero_q;

      unique case (state_q)
         StIdle: begin
            if (win0) begin
               a_d    = a0;
               b_d    = b0;
               op_d   = op0;
               sel_d  = 1'b0;
               gnt0_d = 1'b1;
            end else if (win1) begin
               a_d    = a1;
               b_d    = b1;
               op_d   = op1;
               sel_d  = 1'b1;
               gnt1_d = 1'b1;
            end
         end
         StExec: begin
            // The latched operands have been on the ALU for a full cycle.
            res_d   = alu_y;
            zero_d  = alu_zero;
            done0_d = !sel_q;
            done1_d = sel_q;
            last_d  = sel_q;
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign done0    = done0_q;
   assign done1    = done1_q;
   assign res      = res_q;
   assign res_zero = zero_q;
   assign busy     = (state_q != StIdle);
   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign alu_op   = op_q;

`ifndef SYNTHESIS
   a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset_n)
      !(gnt0_q && gnt1_q));
   a_done_onehot: assert property (@(posedge clk) disable iff (!reset_n)
      !(done0_q && done1_q));
   a_gnt_in_exec: assert property (@(posedge clk) disable iff (!reset_n)
      (gnt0_q || gnt1_q) |-> (state_q == StExec));
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   logic       clk;
   logic       reset_n;
   logic       req0, req1;
   logic [7:0] a0, b0, a1, b1;
   logic [2:0] op0, op1;

   // Round-robin instance
   logic       rr_gnt0, rr_gnt1, rr_done0, rr_done1, rr_zero, rr_busy, rr_alu_zero;
   logic [7:0] rr_res, rr_alu_a, rr_alu_b, rr_alu_y;
   logic [2:0] rr_alu_op;

   // Fixed-priority instance
   logic       fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_zero, fp_busy, fp_alu_zero;
   logic [7:0] fp_res, fp_alu_a, fp_alu_b, fp_alu_y;
   logic [2:0] fp_alu_op;

   int n_vec;
   int n_fail;

   // Reference ALU used by the bench for both instances.
   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
      case (op)
         3'b000:  return a & b;
         3'b001:  return ~a;
         3'b010:  return a + b;
         3'b011:  return a - b;
         3'b100:  return a | b;
         3'b101:  return a ^ b;
         3'b110:  return {a[6:0], 1'b0};
         default: return b;
      endcase
   endfunction

   assign rr_alu_y    = alu_f(rr_alu_a, rr_alu_b, rr_alu_op);
   assign rr_alu_zero = (rr_alu_y == 8'h00);
   assign fp_alu_y    = alu_f(fp_alu_a, fp_alu_b, fp_alu_op);
   assign fp_alu_zero = (fp_alu_y == 8'h00);

   alu_arbiter #(.FIXED_PRIO(0)) dut_rr (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
      .gnt0(rr_gnt0), .gnt1(rr_gnt1), .done0(rr_done0), .done1(rr_done1),
      .res(rr_res), .res_zero(rr_zero), .busy(rr_busy),
      .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_op(rr_alu_op),
      .alu_y(rr_alu_y), .alu_zero(rr_alu_zero)
   );

   alu_arbiter #(.FIXED_PRIO(1)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
      .gnt0(fp_gnt0), .gnt1(fp_gnt1), .done0(fp_done0), .done1(fp_done1),
      .res(fp_res), .res_zero(fp_zero), .busy(fp_busy),
      .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_op(fp_alu_op),
      .alu_y(fp_alu_y), .alu_zero(fp_alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       r0;
      logic       r1;
      logic [7:0] a0;
      logic [7:0] b0;
      logic [2:0] o0;
      logic [7:0] a1;
      logic [7:0] b1;
      logic [2:0] o1;
      logic       win;     // expected round-robin winner
      logic       win_fp;  // expected fixed-priority winner
      logic [7:0] res;     // expected round-robin result
      logic       zero;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic drop_reqs();
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   initial begin
      n_vec   = 0;
      n_fail  = 0;
      reset_n = 1'b0;
      req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;

      //       r0 r1  a0     b0     o0      a1     b1     o1      win fp  res    z
      vecs[0] = '{1'b1, 1'b0, 8'h7F, 8'h01, 3'b010, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 8'h80, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 3'b000, 8'h05, 8'h05, 3'b011, 1'b1, 1'b1, 8'h00, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 8'h12, 8'h34, 3'b000, 8'h0F, 8'h00, 3'b001, 1'b0, 1'b0, 8'h10, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 8'h80, 8'h80, 3'b010, 8'hAA, 8'h55, 3'b101, 1'b1, 1'b0, 8'hFF, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 3'b000, 8'h81, 8'h00, 3'b110, 1'b1, 1'b1, 8'h02, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 3'b100, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 8'h3C, 8'hC3, 3'b111, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 8'hC3, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 8'h11, 8'h22, 3'b100, 8'h01, 8'h02, 3'b011, 1'b1, 1'b0, 8'hFF, 1'b0};

      // Reset values
      #12;
      check("rst gnt0", rr_gnt0, 0);
      check("rst gnt1", rr_gnt1, 0);
      check("rst done0", rr_done0, 0);
      check("rst done1", rr_done1, 0);
      check("rst busy", rr_busy, 0);
      check("rst res", rr_res, 8'h00);
      check("rst res_zero", rr_zero, 0);
      check("rst alu_a", rr_alu_a, 8'h00);
      check("rst alu_b", rr_alu_b, 8'h00);
      check("rst alu_op", rr_alu_op, 3'b000);
      @(negedge clk);
      reset_n = 1'b1;

      // Table of single transactions from IDLE
      for (int i = 0; i < 8; i++) begin
         req0 = vecs[i].r0; a0 = vecs[i].a0; b0 = vecs[i].b0; op0 = vecs[i].o0;
         req1 = vecs[i].r1; a1 = vecs[i].a1; b1 = vecs[i].b1; op1 = vecs[i].o1;
         tick();
         check($sformatf("v%0d gnt0", i), rr_gnt0, !vecs[i].win);
         check($sformatf("v%0d gnt1", i), rr_gnt1, vecs[i].win);
         check($sformatf("v%0d busy exec", i), rr_busy, 1);
         check($sformatf("v%0d alu_a", i), rr_alu_a, vecs[i].win ? vecs[i].a1 : vecs[i].a0);
         check($sformatf("v%0d fp gnt0", i), fp_gnt0, !vecs[i].win_fp);
         tick();
         check($sformatf("v%0d done0", i), rr_done0, !vecs[i].win);
         check($sformatf("v%0d done1", i), rr_done1, vecs[i].win);
         check($sformatf("v%0d res", i), rr_res, vecs[i].res);
         check($sformatf("v%0d res_zero", i), rr_zero, vecs[i].zero);
         check($sformatf("v%0d gnt clr", i), rr_gnt0 | rr_gnt1, 0);
         check($sformatf("v%0d fp done0", i), fp_done0, !vecs[i].win_fp);
         drop_reqs();
         tick();
         check($sformatf("v%0d busy idle", i), rr_busy, 0);
         check($sformatf("v%0d done clr", i), rr_done0 | rr_done1, 0);
         check($sformatf("v%0d res hold", i), rr_res, vecs[i].res);
      end

      // Continuous contention right after reset: RR alternates starting with
      // port 0 at 3-cycle spacing; fixed priority always serves port 0.
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      req0 = 1; a0 = 8'hFF; b0 = 8'h01; op0 = 3'b010;
      req1 = 1; a1 = 8'h0F; b1 = 8'h00; op1 = 3'b001;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rr%0d gnt0", i), rr_gnt0, (i % 2) == 0);
         check($sformatf("rr%0d gnt1", i), rr_gnt1, (i % 2) == 1);
         check($sformatf("fp%0d gnt0", i), fp_gnt0, 1);
         tick();
         check($sformatf("rr%0d done0", i), rr_done0, (i % 2) == 0);
         check($sformatf("rr%0d done1", i), rr_done1, (i % 2) == 1);
         check($sformatf("rr%0d res", i), rr_res, ((i % 2) == 0) ? 8'h00 : 8'hF0);
         check($sformatf("rr%0d res_zero", i), rr_zero, (i % 2) == 0);
         check($sformatf("fp%0d done0", i), fp_done0, 1);
         check($sformatf("fp%0d done1", i), fp_done1, 0);
         check($sformatf("fp%0d res", i), fp_res, 8'h00);
         tick();
         check($sformatf("rr%0d idle", i), rr_busy, 0);
      end
      drop_reqs();
      tick();

      // Operand change and request drop during EXEC do not disturb the result.
      req0 = 1; a0 = 8'h10; b0 = 8'h20; op0 = 3'b010;
      tick();
      check("lat gnt0", rr_gnt0, 1);
      a0 = 8'h99; req0 = 0;
      #2;
      check("lat alu_a", rr_alu_a, 8'h10);
      tick();
      check("lat done0", rr_done0, 1);
      check("lat res", rr_res, 8'h30);
      tick();
      tick();
      check("lat no retrigger", rr_busy, 0);

      // Reset mid-EXEC aborts cleanly.
      req1 = 1; a1 = 8'h0F; b1 = 8'h00; op1 = 3'b001;
      tick();
      check("abort gnt1", rr_gnt1, 1);
      #2;
      reset_n = 1'b0;
      req1 = 0;
      #1;
      check("abort gnt1 clr", rr_gnt1, 0);
      check("abort busy", rr_busy, 0);
      check("abort res", rr_res, 8'h00);
      check("abort alu_a", rr_alu_a, 8'h00);
      check("abort alu_op", rr_alu_op, 3'b000);
      check("abort done1", rr_done1, 0);
      tick();
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("post done1 a", rr_done1, 0);
      check("post busy", rr_busy, 0);
      tick();
      check("post done1 b", rr_done1, 0);
      req0 = 1; a0 = 8'h7F; b0 = 8'h01; op0 = 3'b010;
      tick();
      check("post gnt0", rr_gnt0, 1);
      tick();
      check("post done0", rr_done0, 1);
      check("post res", rr_res, 8'h80);
      check("post res_zero", rr_zero, 0);
      drop_reqs();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, meaning 0 = round-robin between ports, 1 = port 0 always wins simultaneous requests.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 req0, req1  input  1 each  request from port 0 / port 1; held high with stable operands until that port's done.
REQ-005 a0, b0, a1, b1  input  8 each  operands per port.
REQ-006 op0, op1  input  3 each  ALU operation code per port, passed to the ALU unchanged.
REQ-007 gnt0, gnt1  output  1 each  registered; high during the EXEC cycle of that port's transaction.
REQ-008 done0, done1  output  1 each  registered one-cycle pulse; the result for that port is valid.
REQ-009 res  output  8  registered ALU result of the last completed transaction.
REQ-010 res_zero  output  1  registered ALU zero flag of the last completed transaction.
REQ-011 busy  output  1  high in EXEC and DONE states.
REQ-012 alu_a, alu_b  output  8 each  operands to the shared ALU, driven from the internal operand latches.
REQ-013 alu_op  output  3  operation code to the ALU, driven from the internal latch.
REQ-014 alu_y  input  8  combinational ALU result.
REQ-015 alu_zero  input  1  combinational ALU zero flag.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-017 IDLE, no request: stay in IDLE.
REQ-018 IDLE, any request: at the clock edge, latch the winner's a/b/op into the operand latches, set the matching gnt, and go to EXEC.
REQ-019 Round-robin (FIXED_PRIO=0), both requests high: grant the port not served last; a single request is granted regardless of history.
REQ-020 FIXED_PRIO=1, both requests high: grant port 0.
REQ-021 EXEC lasts exactly one cycle.
REQ-022 EXEC edge: capture alu_y into res and alu_zero into res_zero; clear gnt; pulse the matching done for one cycle; record the served port as last-served; go to DONE.
REQ-023 DONE lasts exactly one cycle and always returns to IDLE, where arbitration reruns on current req levels.
REQ-024 Latency: a request sampled in IDLE at edge k gives gnt high in cycle k+1 and done high in cycle k+2; minimum issue interval per transaction is 3 cycles.
REQ-025 A requester SHALL deassert req in the cycle its done is high; req still high in the following IDLE starts a new transaction with the then-current operands.
REQ-026 Operands are latched; changes to a*/b*/op* or req deassertion during EXEC/DONE do not affect the transaction in flight, which completes and pulses done.
REQ-027 Requests arriving during EXEC/DONE are not lost; they are arbitrated at the next IDLE.
REQ-028 Results are 8-bit modulo 2^8 as returned by the ALU; the controller adds no arithmetic.
REQ-029 At most one of gnt0/gnt1 is high, and at most one of done0/done1 is high, in any cycle.
REQ-030 res/res_zero hold their value until the next EXEC edge.

Reset
REQ-031 reset_n low SHALL, asynchronously and in any state including mid-transaction, force: state=IDLE; gnt0=gnt1=0; done0=done1=0; busy=0; res=0x00; res_zero=0; operand latches (alu_a, alu_b, alu_op)=0; last-served=port 1, so port 0 wins the first simultaneous request.
REQ-032 An aborted in-flight transaction SHALL produce no done after reset release; arbitration resumes on the first edge with reset_n high.

Verification
REQ-033 Port 0 requests a=0x7F, b=0x01, op=010 -> gnt0 in cycle k+1; done0 in k+2 with res=0x80, res_zero=0.
REQ-034 Port 1 requests a=0x05, b=0x05, op=011 -> done1 with res=0x00, res_zero=1; gnt0/done0 stay 0.
REQ-035 After reset, both ports request continuously (port0 0xFF+0x01 op=010, port1 a=0x0F op=001) -> order is port0 (res=0x00, zero=1), port1 (res=0xF0), port0, port1 at 3-cycle spacing; with FIXED_PRIO=1, port 0 is served every time.
REQ-036 Port 0 changes a0 and drops req0 during EXEC -> done0 still pulses with the result from the originally latched operands.
REQ-037 reset_n driven low during EXEC -> all outputs immediately take their reset values; no done after release; the next request completes normally.
